// File: rtl/sound_pkg.sv
// Shared sound-controller constants and helpers used by the channel generators.
// Covers the mixer midpoint, divider base, LFSR seed and NRx3 field layout.
package sound_pkg;
    localparam int DIV_BASE_DEF   = 8;
    localparam int NRX3_SHIFT_LSB = 4;
    localparam int NRX3_WIDTH_BIT = 3;
    localparam int NRX3_RATIO_LSB = 0;
    localparam int SHIFT_MAX      = 13;

    function automatic int unsigned mid_level(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] lfsr_seed(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Shift counts above SHIFT_MAX overflow here; callers gate shifting off for them.
    function automatic logic [31:0] div_period(input logic [2:0] r, input logic [3:0] s,
                                               input int unsigned base);
        logic [31:0] t;
        t = (r == 3'd0) ? base : ((base * 32'(r)) << 1);
        return t << s;
    endfunction
endpackage

// File: rtl/noise_lfsr.sv
// Noise LFSR with long/short feedback; shared with the wave-noise channel variant.
module noise_lfsr import sound_pkg::*; #(
    parameter int LFSR_WIDTH = 15,
    parameter int SHORT_TAP  = 7
) (
    input  logic iClock,
    input  logic iReset,
    input  logic iLoad,
    input  logic iShift,
    input  logic iShort,
    output logic oTone
);
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic                  fb;

    always_comb begin
        lfsr_d = lfsr_q;
        fb     = lfsr_q[0] ^ lfsr_q[1];
        if (iLoad) begin
            lfsr_d = LFSR_WIDTH'(lfsr_seed(LFSR_WIDTH));
        end else if (iShift) begin
            lfsr_d = {fb, lfsr_q[LFSR_WIDTH-1:1]};
            if (iShort) lfsr_d[SHORT_TAP-1] = fb;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) lfsr_q <= LFSR_WIDTH'(lfsr_seed(LFSR_WIDTH));
        else        lfsr_q <= lfsr_d;
    end

    assign oTone = ~lfsr_q[0];
endmodule

// File: rtl/sound_noise_channel_gen.sv
// Channel 4 noise generator: divider-clocked LFSR, volume envelope, length timer
// and registered offset-binary output.
module sound_noise_channel_gen import sound_pkg::*; #(
    parameter int LFSR_WIDTH = 15,
    parameter int SHORT_TAP  = 7,
    parameter int OUT_WIDTH  = 5,
    parameter int DIV_BASE   = DIV_BASE_DEF
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iTick64,
    input  logic                 iTick256,
    input  logic                 iTrigger,
    input  logic [7:0]           iNR41,
    input  logic [7:0]           iNR42,
    input  logic [7:0]           iNR43,
    input  logic [7:0]           iNR44,
    output logic [OUT_WIDTH-1:0] oOut,
    output logic                 oEnable
);
    localparam int DIV_W = $clog2(2 * DIV_BASE * 7 * (1 << SHIFT_MAX) + 1);
    localparam logic [OUT_WIDTH:0] MID = (OUT_WIDTH+1)'(mid_level(OUT_WIDTH));

    logic             enable_q, enable_d;
    logic [3:0]       vol_q, vol_d;
    logic             env_dir_q, env_dir_d;
    logic [2:0]       env_per_q, env_per_d, env_cnt_q, env_cnt_d;
    logic             len_en_q, len_en_d;
    logic [6:0]       len_cnt_q, len_cnt_d;
    logic [2:0]       ratio_q, ratio_d;
    logic [3:0]       shift_q, shift_d;
    logic             short_q, short_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [OUT_WIDTH:0]   out_wide, vol_ext;
    logic             shift_en, tone, dac_on;
    logic             unused_bits;

    assign dac_on      = |iNR42[7:3];
    assign unused_bits = ^{iNR41[7:6], iNR44[7], iNR44[5:0]};

    always_comb begin
        enable_d  = enable_q;
        vol_d     = vol_q;
        env_dir_d = env_dir_q;
        env_per_d = env_per_q;
        env_cnt_d = env_cnt_q;
        len_en_d  = len_en_q;
        len_cnt_d = len_cnt_q;
        ratio_d   = ratio_q;
        shift_d   = shift_q;
        short_d   = short_q;
        div_cnt_d = div_cnt_q;
        shift_en  = 1'b0;
        if (iTrigger) begin
            enable_d  = 1'b1;
            vol_d     = iNR42[7:4];
            env_dir_d = iNR42[3];
            env_per_d = iNR42[2:0];
            env_cnt_d = iNR42[2:0];
            len_en_d  = iNR44[6];
            len_cnt_d = 7'd64 - 7'(iNR41[5:0]);
            ratio_d   = iNR43[NRX3_RATIO_LSB +: 3];
            shift_d   = iNR43[NRX3_SHIFT_LSB +: 4];
            short_d   = iNR43[NRX3_WIDTH_BIT];
            div_cnt_d = DIV_W'(div_period(iNR43[NRX3_RATIO_LSB +: 3],
                                          iNR43[NRX3_SHIFT_LSB +: 4], DIV_BASE));
        end else if (enable_q) begin
            if (div_cnt_q <= DIV_W'(1)) begin
                div_cnt_d = DIV_W'(div_period(ratio_q, shift_q, DIV_BASE));
                shift_en  = (shift_q <= 4'(SHIFT_MAX));
            end else begin
                div_cnt_d = div_cnt_q - DIV_W'(1);
            end
            // Envelope period counts down to 1, then reloads and steps with saturation.
            if (iTick64 && env_per_q != 3'd0) begin
                if (env_cnt_q <= 3'd1) begin
                    env_cnt_d = env_per_q;
                    if (env_dir_q && vol_q != 4'd15)       vol_d = vol_q + 4'd1;
                    else if (!env_dir_q && vol_q != 4'd0) vol_d = vol_q - 4'd1;
                end else begin
                    env_cnt_d = env_cnt_q - 3'd1;
                end
            end
            if (iTick256 && len_en_q) begin
                if (len_cnt_q != 7'd0)  len_cnt_d = len_cnt_q - 7'd1;
                if (len_cnt_q <= 7'd1)  enable_d  = 1'b0;
            end
        end
        if (!dac_on) enable_d = 1'b0;
    end

    always_comb begin
        vol_ext  = (OUT_WIDTH+1)'(vol_q);
        out_wide = MID;
        if (enable_q) out_wide = tone ? (MID + vol_ext) : (MID - vol_ext);
        out_d = out_wide[OUT_WIDTH-1:0];
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            enable_q  <= 1'b0;
            vol_q     <= '0;
            env_dir_q <= 1'b0;
            env_per_q <= '0;
            env_cnt_q <= '0;
            len_en_q  <= 1'b0;
            len_cnt_q <= '0;
            ratio_q   <= '0;
            shift_q   <= '0;
            short_q   <= 1'b0;
            div_cnt_q <= '0;
            out_q     <= MID[OUT_WIDTH-1:0];
        end else begin
            enable_q  <= enable_d;
            vol_q     <= vol_d;
            env_dir_q <= env_dir_d;
            env_per_q <= env_per_d;
            env_cnt_q <= env_cnt_d;
            len_en_q  <= len_en_d;
            len_cnt_q <= len_cnt_d;
            ratio_q   <= ratio_d;
            shift_q   <= shift_d;
            short_q   <= short_d;
            div_cnt_q <= div_cnt_d;
            out_q     <= out_d;
        end
    end

    noise_lfsr #(.LFSR_WIDTH(LFSR_WIDTH), .SHORT_TAP(SHORT_TAP)) u_lfsr (
        .iClock (iClock),
        .iReset (iReset),
        .iLoad  (iTrigger),
        .iShift (shift_en),
        .iShort (short_q),
        .oTone  (tone)
    );

    assign oOut    = out_q;
    assign oEnable = enable_q;
endmodule

// File: tb/tb_sound_noise_channel_gen.sv
// Scoreboard bench for the channel 4 noise generator: stimulus queues expected
// samples keyed by cycle, a negedge monitor pops and compares them.
module tb_sound_noise_channel_gen;
    logic       iClock = 1'b0;
    logic       iReset, iTick64, iTick256, iTrigger;
    logic [7:0] iNR41, iNR42, iNR43, iNR44;
    logic [4:0] oOut;
    logic       oEnable;

    sound_noise_channel_gen dut (
        .iClock(iClock), .iReset(iReset), .iTick64(iTick64), .iTick256(iTick256),
        .iTrigger(iTrigger), .iNR41(iNR41), .iNR42(iNR42), .iNR43(iNR43), .iNR44(iNR44),
        .oOut(oOut), .oEnable(oEnable)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        int         due;
        logic [4:0] out;
        logic       en;
        logic       chk_lfsr;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge iClock) cyc <= cyc + 1;

    always @(negedge iClock) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            m_e = sbq.pop_front();
            n_vec++;
            if (m_e.due != cyc || oOut !== m_e.out || oEnable !== m_e.en ||
                (m_e.chk_lfsr && dut.u_lfsr.lfsr_q !== 15'h7FFF)) begin
                n_bad++;
                $display("FAIL %s @%0d (due %0d): oOut=%0d oEnable=%0b lfsr=%h, want oOut=%0d oEnable=%0b%s",
                         m_e.name, cyc, m_e.due, oOut, oEnable, dut.u_lfsr.lfsr_q,
                         m_e.out, m_e.en, m_e.chk_lfsr ? " lfsr=7fff" : "");
            end
        end
    end

    task automatic expect_at(input int due, input int out, input bit en, input bit cl,
                             input string nm);
        exp_t e;
        int   pos;
        e.due = due; e.out = 5'(out); e.en = en; e.chk_lfsr = cl; e.name = nm;
        pos = sbq.size();
        while (pos > 0 && sbq[pos-1].due > due) pos--;
        sbq.insert(pos, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iClock);
    endtask

    task automatic do_trigger(input bit tick256, output int t);
        iTrigger = 1'b1; iTick256 = tick256;
        @(negedge iClock);
        t = cyc; iTrigger = 1'b0; iTick256 = 1'b0;
    endtask

    task automatic pulse(input bit t64, output int e);
        if (t64) iTick64 = 1'b1; else iTick256 = 1'b1;
        @(negedge iClock);
        e = cyc; iTick64 = 1'b0; iTick256 = 1'b0;
    endtask

    // Tone bits after k shifts from the all-ones seed, bit k = tone.
    logic [31:0] long_tone  = 32'hDFFF_8000;
    logic [15:0] short_tone = 16'hDF80;

    initial begin
        int t, e, k, r;
        iReset = 1'b1; iTick64 = 0; iTick256 = 0; iTrigger = 0;
        iNR41 = 0; iNR42 = 0; iNR43 = 0; iNR44 = 0;
        @(negedge iClock);
        expect_at(cyc + 1, 15, 0, 1, "reset_state");
        idle(2);
        iReset = 1'b0;
        idle(1);

        // Long mode, T = 8 cycles, full volume: output swings 0 / 30.
        iNR42 = 8'hF0; iNR43 = 8'h00;
        do_trigger(0, t);
        for (k = 0; k < 32; k++)
            expect_at(t + 8*k + 4, long_tone[k] ? 30 : 0, 1, 0, $sformatf("long_k%0d", k));
        idle(8*32 + 6);

        // Reset mid-tone, with a trigger attempted while reset is held.
        iReset = 1'b1;
        r = cyc + 1;
        expect_at(r, 15, 0, 1, "reset_mid");
        expect_at(r + 2, 15, 0, 1, "reset_over_trig");
        expect_at(r + 4, 15, 0, 0, "post_reset");
        idle(1); iTrigger = 1'b1;
        idle(1); iTrigger = 1'b0;
        idle(1); iReset = 1'b0;
        idle(4);

        // Short mode: 127-shift period.
        iNR43 = 8'h08;
        do_trigger(0, t);
        for (k = 0; k < 16; k++) begin
            expect_at(t + 8*k + 4, short_tone[k] ? 30 : 0, 1, 0, $sformatf("short_k%0d", k));
            expect_at(t + 8*(k+127) + 4, short_tone[k] ? 30 : 0, 1, 0,
                      $sformatf("short_k%0d", k + 127));
        end
        idle(8*143 + 6);

        // Envelope down, P=1, LFSR frozen (s=14) so tone stays 0.
        iNR43 = 8'hE0; iNR42 = 8'h81;
        do_trigger(0, t);
        expect_at(t + 3, 7, 1, 0, "env_dn_start");
        idle(4);
        for (k = 1; k <= 9; k++) begin
            pulse(1, e);
            expect_at(e + 3, (7 + k > 15) ? 15 : 7 + k, 1, 0, $sformatf("env_dn_%0d", k));
            idle(4);
        end

        // Envelope up, P=2, saturating at 15.
        iNR42 = 8'hEA;
        do_trigger(0, t);
        expect_at(t + 3, 1, 1, 0, "env_up_start");
        idle(4);
        for (k = 1; k <= 4; k++) begin
            pulse(1, e);
            expect_at(e + 3, (k >= 2) ? 0 : 1, 1, 0, $sformatf("env_up_%0d", k));
            idle(4);
        end

        // Length 64-62 = 2 ticks.
        iNR42 = 8'hF0; iNR41 = 8'h3E; iNR44 = 8'h40;
        do_trigger(0, t);
        expect_at(t + 3, 0, 1, 0, "len_start");
        idle(4);
        pulse(0, e); expect_at(e + 3, 0, 1, 0, "len_tick1"); idle(4);
        pulse(0, e); expect_at(e + 3, 15, 0, 0, "len_tick2"); idle(4);

        // Retrigger coincident with a length tick while the counter is at 1.
        iNR41 = 8'h3F;
        do_trigger(0, t);
        idle(3);
        iNR41 = 8'h3E;
        do_trigger(1, t);
        expect_at(t + 3, 0, 1, 0, "trig_over_tick");
        idle(4);
        pulse(0, e); expect_at(e + 3, 0, 1, 0, "retrig_tick1"); idle(4);
        pulse(0, e); expect_at(e + 3, 15, 0, 0, "retrig_tick2"); idle(4);

        // DAC switched off while running.
        iNR44 = 8'h00;
        do_trigger(0, t);
        idle(5);
        iNR42 = 8'h00;
        expect_at(cyc + 1, 0, 0, 0, "dac_off_en");
        expect_at(cyc + 2, 15, 0, 0, "dac_off_out");
        idle(4);

        // Trigger with DAC off keeps the channel disabled.
        iNR42 = 8'h07;
        do_trigger(0, t);
        expect_at(t + 2, 15, 0, 0, "dac_off_trig");

        for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge iClock);
        if (sbq.size() > 0) begin
            $display("FAIL drain: %0d expected samples never compared, want 0", sbq.size());
            n_bad += sbq.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
